// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl
//   Run controller for the pipelined RV32 core. Holds the core in reset for a
//   fixed number of cycles after controller reset, then lets it run while
//   watching for end-of-test: a tohost mailbox write (pass/fail), a global
//   timeout, or a retire stall (hang). The first terminal condition is latched
//   and kept until the next rst, together with cycle and retired-instruction
//   counters frozen at their last RUN values.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   core_rst          registered active-high reset to the core
//   retire_valid      one pulse per retired instruction
//   mem_wr_en/addr/data  snooped data-memory write port
//   done              any terminal state reached (sticky)
//   pass/fail/timeout/hang  individual terminal flags (sticky, one-hot)
//   fail_code         upper DATA_WIDTH-1 bits of the failing tohost value
//   state             FSM state: 0 HOLD, 1 RUN, 2 PASS, 3 FAIL, 4 TIMEOUT, 5 HANG
//   cycle_count       RUN cycles elapsed (saturating)
//   instret_count     retire pulses seen in RUN (saturating)
module sim_run_ctrl #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter int                    RESET_CYCLES   = 2,
  parameter int                    TIMEOUT_CYCLES = 100000,
  parameter int                    STALL_LIMIT    = 64,
  parameter int                    CNT_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  core_rst,
  input  logic                  retire_valid,
  input  logic                  mem_wr_en,
  input  logic [ADDR_WIDTH-1:0] mem_wr_addr,
  input  logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic                  hang,
  output logic [DATA_WIDTH-2:0] fail_code,
  output logic [2:0]            state,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic [CNT_WIDTH-1:0]  instret_count
);

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4,
    ST_HANG    = 3'd5
  } state_e;

  localparam int HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int STALL_W = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;

  localparam logic [HOLD_W-1:0]    HOLD_LAST    = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [STALL_W-1:0]   STALL_LAST   = STALL_W'((STALL_LIMIT > 0) ? STALL_LIMIT - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX      = '1;
  localparam logic [DATA_WIDTH-1:0] DATA_ONE    = DATA_WIDTH'(1);

  state_e                state_q, state_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [STALL_W-1:0]    stall_q, stall_d;
  logic [CNT_WIDTH-1:0]  cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0]  instret_q, instret_d;
  logic [DATA_WIDTH-2:0] fail_code_q, fail_code_d;
  logic                  core_rst_q, core_rst_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  fail_q, fail_d;
  logic                  timeout_q, timeout_d;
  logic                  hang_q, hang_d;
  logic                  tohost_hit;

  // Next-state and counter logic. Terminal states hold everything, so the
  // counters keep the value written on the last RUN edge (which itself still
  // counts, e.g. a retire coinciding with the pass write).
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    stall_d     = stall_q;
    cycle_d     = cycle_q;
    instret_d   = instret_q;
    fail_code_d = fail_code_q;
    tohost_hit  = mem_wr_en && (mem_wr_addr == TOHOST_ADDR);

    case (state_q)
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      ST_RUN: begin
        if (cycle_q != CNT_MAX) begin
          cycle_d = cycle_q + CNT_WIDTH'(1);
        end
        if (retire_valid && (instret_q != CNT_MAX)) begin
          instret_d = instret_q + CNT_WIDTH'(1);
        end
        if (STALL_LIMIT > 0) begin
          if (retire_valid) begin
            stall_d = '0;
          end else if (stall_q != STALL_LAST) begin
            stall_d = stall_q + STALL_W'(1);
          end
        end

        // Priority: tohost write, then timeout, then hang.
        if (tohost_hit && (mem_wr_data == DATA_ONE)) begin
          state_d = ST_PASS;
        end else if (tohost_hit && mem_wr_data[0]) begin
          state_d     = ST_FAIL;
          fail_code_d = mem_wr_data[DATA_WIDTH-1:1];
        end else if (cycle_q == TIMEOUT_LAST) begin
          state_d = ST_TIMEOUT;
        end else if ((STALL_LIMIT > 0) && !retire_valid && (stall_q == STALL_LAST)) begin
          state_d = ST_HANG;
        end
      end

      ST_PASS, ST_FAIL, ST_TIMEOUT, ST_HANG: begin
        state_d = state_q;
      end

      default: begin
        state_d = ST_HOLD;
      end
    endcase

    // Outputs are decoded from the next state so they land in flops
    // alongside the state register.
    core_rst_d = (state_d == ST_HOLD);
    pass_d     = (state_d == ST_PASS);
    fail_d     = (state_d == ST_FAIL);
    timeout_d  = (state_d == ST_TIMEOUT);
    hang_d     = (state_d == ST_HANG);
    done_d     = pass_d || fail_d || timeout_d || hang_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HOLD;
      hold_q      <= '0;
      stall_q     <= '0;
      cycle_q     <= '0;
      instret_q   <= '0;
      fail_code_q <= '0;
      core_rst_q  <= 1'b1;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      hang_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      stall_q     <= stall_d;
      cycle_q     <= cycle_d;
      instret_q   <= instret_d;
      fail_code_q <= fail_code_d;
      core_rst_q  <= core_rst_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      hang_q      <= hang_d;
    end
  end

  assign state         = state_q;
  assign core_rst      = core_rst_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign fail          = fail_q;
  assign timeout       = timeout_q;
  assign hang          = hang_q;
  assign fail_code     = fail_code_q;
  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Testbench for sim_run_ctrl. Two instances share one set of inputs:
//   A: TIMEOUT_CYCLES=200, STALL_LIMIT=8
//   B: TIMEOUT_CYCLES=20,  STALL_LIMIT=0 (hang detection disabled)
// A reference model per instance tracks the run as a reset countdown plus an
// outcome, and every cycle both instances are compared against it. Directed
// scenarios add literal expectations on top.
module tb_sim_run_ctrl;

  localparam logic [31:0] TOHOST = 32'h0000_1000;
  localparam int RESET_CYCLES = 2;
  localparam longint CNT_MAX = 64'hFFFF_FFFF;

  localparam int OUT_NONE    = 0;
  localparam int OUT_PASS    = 2;
  localparam int OUT_FAIL    = 3;
  localparam int OUT_TIMEOUT = 4;
  localparam int OUT_HANG    = 5;

  logic        clk;
  logic        rst;
  logic        retireValid;
  logic        memWrEn;
  logic [31:0] memWrAddr;
  logic [31:0] memWrData;

  logic        coreRstA, doneA, passA, failA, timeoutA, hangA;
  logic [30:0] failCodeA;
  logic [2:0]  stateA;
  logic [31:0] cycleCountA, instretCountA;

  logic        coreRstB, doneB, passB, failB, timeoutB, hangB;
  logic [30:0] failCodeB;
  logic [2:0]  stateB;
  logic [31:0] cycleCountB, instretCountB;

  int checkCount = 0;
  int failCount  = 0;

  typedef struct {
    int     holdLeft;
    int     outcome;
    longint cycles;
    longint instret;
    int     idle;
    longint fcode;
  } model_t;

  model_t mdl [2];
  int     mdlTimeout [2];
  int     mdlStall [2];

  sim_run_ctrl #(.TIMEOUT_CYCLES(200), .STALL_LIMIT(8)) dutA (
    .clk(clk), .rst(rst), .core_rst(coreRstA), .retire_valid(retireValid),
    .mem_wr_en(memWrEn), .mem_wr_addr(memWrAddr), .mem_wr_data(memWrData),
    .done(doneA), .pass(passA), .fail(failA), .timeout(timeoutA), .hang(hangA),
    .fail_code(failCodeA), .state(stateA), .cycle_count(cycleCountA),
    .instret_count(instretCountA)
  );

  sim_run_ctrl #(.TIMEOUT_CYCLES(20), .STALL_LIMIT(0)) dutB (
    .clk(clk), .rst(rst), .core_rst(coreRstB), .retire_valid(retireValid),
    .mem_wr_en(memWrEn), .mem_wr_addr(memWrAddr), .mem_wr_data(memWrData),
    .done(doneB), .pass(passB), .fail(failB), .timeout(timeoutB), .hang(hangB),
    .fail_code(failCodeB), .state(stateB), .cycle_count(cycleCountB),
    .instret_count(instretCountB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: reset starts a countdown of core_rst cycles; once it
  // reaches zero the run is live until the first terminal outcome.
  function automatic void modelStep(input int i, input bit r, input bit rv, input bit we,
                                    input logic [31:0] a, input logic [31:0] d);
    bit hit;
    if (r) begin
      mdl[i] = '{holdLeft: RESET_CYCLES, outcome: OUT_NONE, cycles: 0, instret: 0, idle: 0, fcode: 0};
    end else if (mdl[i].holdLeft > 0) begin
      mdl[i].holdLeft--;
    end else if (mdl[i].outcome == OUT_NONE) begin
      if (mdl[i].cycles < CNT_MAX) mdl[i].cycles++;
      if (rv && mdl[i].instret < CNT_MAX) mdl[i].instret++;
      mdl[i].idle = rv ? 0 : mdl[i].idle + 1;
      hit = we && (a == TOHOST);
      if (hit && d == 32'd1) begin
        mdl[i].outcome = OUT_PASS;
      end else if (hit && d[0]) begin
        mdl[i].outcome = OUT_FAIL;
        mdl[i].fcode   = longint'(d >> 1);
      end else if (mdl[i].cycles == longint'(mdlTimeout[i])) begin
        mdl[i].outcome = OUT_TIMEOUT;
      end else if (mdlStall[i] > 0 && mdl[i].idle == mdlStall[i]) begin
        mdl[i].outcome = OUT_HANG;
      end
    end
  endfunction

  task automatic checkAll();
    for (int i = 0; i < 2; i++) begin
      string  n;
      int     expState;
      logic   oCore, oDone, oPass, oFail, oTo, oHang;
      logic [30:0] oCode;
      logic [2:0]  oState;
      logic [31:0] oCyc, oRet;
      n = (i == 0) ? "A" : "B";
      if (i == 0) begin
        oCore = coreRstA; oDone = doneA; oPass = passA; oFail = failA; oTo = timeoutA;
        oHang = hangA; oCode = failCodeA; oState = stateA; oCyc = cycleCountA; oRet = instretCountA;
      end else begin
        oCore = coreRstB; oDone = doneB; oPass = passB; oFail = failB; oTo = timeoutB;
        oHang = hangB; oCode = failCodeB; oState = stateB; oCyc = cycleCountB; oRet = instretCountB;
      end
      expState = (mdl[i].holdLeft > 0) ? 0 : ((mdl[i].outcome == OUT_NONE) ? 1 : mdl[i].outcome);
      checkOutput({n, ".core_rst"}, 64'(oCore), 64'(mdl[i].holdLeft > 0));
      checkOutput({n, ".state"}, 64'(oState), 64'(expState));
      checkOutput({n, ".done"}, 64'(oDone), 64'(mdl[i].outcome != OUT_NONE));
      checkOutput({n, ".pass"}, 64'(oPass), 64'(mdl[i].outcome == OUT_PASS));
      checkOutput({n, ".fail"}, 64'(oFail), 64'(mdl[i].outcome == OUT_FAIL));
      checkOutput({n, ".timeout"}, 64'(oTo), 64'(mdl[i].outcome == OUT_TIMEOUT));
      checkOutput({n, ".hang"}, 64'(oHang), 64'(mdl[i].outcome == OUT_HANG));
      checkOutput({n, ".fail_code"}, 64'(oCode), 64'(mdl[i].fcode));
      checkOutput({n, ".cycle_count"}, 64'(oCyc), 64'(mdl[i].cycles));
      checkOutput({n, ".instret_count"}, 64'(oRet), 64'(mdl[i].instret));
    end
  endtask

  // Drive one cycle of inputs, step the model on the edge, check 1ns later.
  task automatic applyStimulus(input bit r, input bit rv, input bit we,
                               input logic [31:0] a, input logic [31:0] d);
    rst = r; retireValid = rv; memWrEn = we; memWrAddr = a; memWrData = d;
    @(posedge clk);
    for (int i = 0; i < 2; i++) modelStep(i, r, rv, we, a, d);
    #1;
    checkAll();
  endtask

  // Three reset cycles, then two hold cycles during which retires and a
  // tohost pass write must be ignored. Leaves both DUTs at RUN cycle 0.
  task automatic resetAndHold();
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1, 1'b1, TOHOST, 32'd1);
    checkOutput("reset.core_rst", 64'(coreRstA), 64'd1);
    checkOutput("reset.state", 64'(stateA), 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, TOHOST, 32'd1);
    checkOutput("hold1.core_rst", 64'(coreRstA), 64'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, TOHOST, 32'd1);
    checkOutput("hold2.core_rst", 64'(coreRstA), 64'd0);
    checkOutput("hold2.state", 64'(stateA), 64'd1);
    checkOutput("hold2.cycle_count", 64'(cycleCountA), 64'd0);
  endtask

  // Retire every cycle, pass write on RUN cycle 50, then 100 cycles of
  // unrelated traffic that must not disturb the sticky result.
  task automatic passRun();
    for (int k = 0; k < 50; k++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, TOHOST, 32'd1);
    checkOutput("pass.pass", 64'(passA), 64'd1);
    checkOutput("pass.state", 64'(stateA), 64'd2);
    checkOutput("pass.cycle_count", 64'(cycleCountA), 64'd51);
    for (int k = 0; k < 100; k++)
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b1, TOHOST, $urandom);
    checkOutput("passHold.cycle_count", 64'(cycleCountA), 64'd51);
    checkOutput("passHold.instret", 64'(instretCountA), 64'd51);
    checkOutput("passHold.done", 64'(doneA), 64'd1);
    checkOutput("timeoutB.timeout", 64'(timeoutB), 64'd1);
    checkOutput("timeoutB.cycle_count", 64'(cycleCountB), 64'd20);
    checkOutput("timeoutB.hang", 64'(hangB), 64'd0);
  endtask

  initial begin
    int retireProb;
    mdlTimeout[0] = 200; mdlStall[0] = 8;
    mdlTimeout[1] = 20;  mdlStall[1] = 0;
    for (int i = 0; i < 2; i++)
      mdl[i] = '{holdLeft: RESET_CYCLES, outcome: OUT_NONE, cycles: 0, instret: 0, idle: 0, fcode: 0};
    rst = 1'b1; retireValid = 1'b0; memWrEn = 1'b0; memWrAddr = '0; memWrData = '0;

    $display("[TB] pass run");
    resetAndHold();
    passRun();

    $display("[TB] fail run");
    resetAndHold();
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, TOHOST, 32'd2);
    applyStimulus(1'b0, 1'b1, 1'b1, TOHOST + 32'd4, 32'd1);
    checkOutput("ignored.state", 64'(stateA), 64'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, TOHOST, 32'h0000_000B);
    checkOutput("fail.fail", 64'(failA), 64'd1);
    checkOutput("fail.fail_code", 64'(failCodeA), 64'd5);
    checkOutput("fail.state", 64'(stateA), 64'd3);
    for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b0, 1'b1, TOHOST, 32'd1);

    $display("[TB] hang run");
    resetAndHold();
    for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 7; k++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("preHang.hang", 64'(hangA), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("hang.hang", 64'(hangA), 64'd1);
    checkOutput("hang.instret", 64'(instretCountA), 64'd10);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("noHangB.timeout", 64'(timeoutB), 64'd1);
    checkOutput("noHangB.hang", 64'(hangB), 64'd0);

    $display("[TB] pass on timeout cycle");
    resetAndHold();
    for (int k = 0; k < 19; k++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, TOHOST, 32'd1);
    checkOutput("passVsTimeout.pass", 64'(passB), 64'd1);
    checkOutput("passVsTimeout.timeout", 64'(timeoutB), 64'd0);
    checkOutput("passVsTimeout.cycle_count", 64'(cycleCountB), 64'd20);

    $display("[TB] mid-run reset");
    resetAndHold();
    for (int k = 0; k < 30; k++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    checkOutput("midRst.core_rst", 64'(coreRstA), 64'd1);
    checkOutput("midRst.cycle_count", 64'(cycleCountA), 64'd0);
    checkOutput("midRst.timeoutB", 64'(timeoutB), 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    checkOutput("midRst.hold1", 64'(coreRstA), 64'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    checkOutput("midRst.hold2", 64'(coreRstA), 64'd0);
    passRun();

    $display("[TB] random traffic");
    retireProb = 3;
    for (int k = 0; k < 4000; k++) begin
      bit          r, rv, we;
      logic [31:0] a, d;
      r = ($urandom_range(0, 249) == 0);
      if (r) retireProb = $urandom_range(0, 4);
      rv = ($urandom_range(0, 3) < retireProb);
      we = ($urandom_range(0, 7) == 0);
      a  = ($urandom_range(0, 1) == 0) ? TOHOST : (TOHOST ^ (32'd1 << $urandom_range(0, 31)));
      d  = $urandom & 32'hFFFF_FFFE;
      if ($urandom_range(0, 29) == 0) d = ($urandom_range(0, 1) == 0) ? 32'd1 : ($urandom | 32'd1);
      applyStimulus(r, rv, we, a, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/sim_run_ctrl.md
Name: sim_run_ctrl

Overview:
- Synthesizable run controller for the pipelined RV32 core. Replaces fixed-duration simulation runs with detected end-of-test.
- Generates the core reset pulse after controller reset.
- Snoops data-memory writes for a tohost mailbox to detect pass/fail.
- Detects timeout and retire-stall hang, and reports a sticky final status plus cycle/instret counters to the bench or an FPGA status register.

Parameters:
ADDR_WIDTH, 32, data-memory address width
DATA_WIDTH, 32, data-memory write data width
TOHOST_ADDR, 32'h0000_1000, byte address of tohost mailbox (compared over ADDR_WIDTH bits)
RESET_CYCLES, 2, cycles core_rst stays asserted after rst deasserts (>=1)
TIMEOUT_CYCLES, 100000, RUN cycles before timeout (>=1)
STALL_LIMIT, 64, consecutive RUN cycles with no retire before hang; 0 disables hang detection
CNT_WIDTH, 32, width of cycle_count and instret_count

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
core_rst  output  1  active-high reset to core, registered
retire_valid  input  1  one pulse per retired instruction
mem_wr_en  input  1  data-memory write strobe
mem_wr_addr  input  ADDR_WIDTH  data-memory write address
mem_wr_data  input  DATA_WIDTH  data-memory write data
done  output  1  test finished (any terminal state), sticky
pass  output  1  tohost reported pass, sticky
fail  output  1  tohost reported failure, sticky
timeout  output  1  timeout reached, sticky
hang  output  1  stall limit reached, sticky
fail_code  output  DATA_WIDTH-1  mem_wr_data[DATA_WIDTH-1:1] of failing tohost write
state  output  3  FSM state encoding
cycle_count  output  CNT_WIDTH  RUN cycles elapsed
instret_count  output  CNT_WIDTH  retire pulses counted in RUN

Behaviour:
- Reset values, sampled on clk while rst=1:
  - core_rst=1, state=HOLD(0).
  - All flags, fail_code, counters, hold counter and stall counter = 0.
- rst mid-operation: returns to HOLD within one cycle regardless of state. core_rst reasserts on the next edge.
- States and transitions:
  - HOLD=0:
    - core_rst=1. Hold counter increments each cycle.
    - On the edge where hold count reaches RESET_CYCLES-1, go to RUN and drop core_rst. core_rst is therefore high for exactly RESET_CYCLES cycles after rst falls.
    - retire_valid and mem writes are ignored.
  - RUN=1:
    - cycle_count increments every cycle. instret_count increments when retire_valid=1.
    - Both counters saturate at all-ones and do not wrap.
  - PASS=2, FAIL=3, TIMEOUT=4, HANG=5:
    - Terminal and sticky until rst. done=1.
    - Counters freeze at their values from the last RUN cycle. core_rst stays 0.
- tohost decode, in RUN only: hit = mem_wr_en && mem_wr_addr==TOHOST_ADDR.
  - data==1: go to PASS, pass=1.
  - data odd and !=1: go to FAIL, fail=1, fail_code=data>>1.
  - data even, including 0: ignored and stays in RUN.
- Timeout: in RUN, when cycle_count==TIMEOUT_CYCLES-1 at the edge, go to TIMEOUT. The TIMEOUT_CYCLES-th RUN cycle is the last one counted.
- Hang, STALL_LIMIT>0:
  - Stall counter resets to 0 on retire_valid and increments otherwise.
  - Reaching STALL_LIMIT-1 with no retire in that cycle goes to HANG.
- Same-cycle priority: tohost hit > timeout > hang. Exactly one terminal flag is ever set.
- The counter on the terminal cycle still updates: a retire on the cycle of the pass write is counted.
- All outputs are registered. Flags rise one cycle after the causing input edge. No combinational input-to-output paths.
- Flag outputs are decoded from registered state only.

Test Plan:
- rst high 3 cycles, low -> core_rst high exactly RESET_CYCLES=2 cycles after rst falls. state 0->1. cycle_count starts at 0.
- RUN, retire every cycle; write 32'h1 to 0x1000 on RUN cycle 50 -> pass=1, done=1, state=2 next cycle. cycle_count=51 frozen; flags stable for 100 further cycles.
- Write 32'h0000_000B to 0x1000 -> fail=1, fail_code=5, state=3. A prior write of 32'h2 to 0x1000 and a write of 32'h1 to 0x1004 are both ignored.
- TIMEOUT_CYCLES=20, STALL_LIMIT=0, retire every cycle, no tohost -> timeout=1 after 20 RUN cycles, cycle_count=20, hang=0.
- STALL_LIMIT=8, retire for 10 cycles then stop -> hang=1 after 8 idle cycles, instret_count=10. Separately, a pass write on the same cycle the timeout fires -> pass=1, timeout=0.
- rst pulsed 1 cycle while in RUN at cycle 30 -> all flags and counters 0, core_rst reasserted for 2 cycles, full run repeats identically.
